// File: rtl/tisc_pkg.sv
// Shared TISC definitions: default datapath widths and the data-memory responder states.
package tisc_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Word storage for dmem_responder: synchronous write, combinational read, no reset.
module dmem_array #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: req/ack handshake with fixed wait states and saturating debug counters.
module dmem_responder
    import tisc_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt
);

    localparam int WCW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    dmem_state_t       r_state;
    dmem_state_t       w_next;
    logic [WCW-1:0]    r_wcnt;
    logic              r_we_q;
    logic [ADDR_W-1:0] r_addr_q;
    logic [DATA_W-1:0] r_wdata_q;
    logic              r_ack;
    logic              r_busy;
    logic [DATA_W-1:0] r_rdata;
    logic [CNT_W-1:0]  r_rd_cnt;
    logic [CNT_W-1:0]  r_wr_cnt;

    logic              w_accept;
    logic              w_access;
    logic              w_mem_we;
    logic              w_ack_d;
    logic              w_busy_d;
    logic [DATA_W-1:0] w_mem_rdata;

    assign w_accept = (r_state == IDLE) && req;
    assign w_access = (r_state == WAIT) && (r_wcnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (req) w_next = WAIT;
            WAIT:    if (r_wcnt == '0) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ack/busy are registered from the next state so they line up with the state they describe
    always_comb begin
        w_mem_we = w_access && r_we_q;
        w_ack_d  = (w_next == RESP);
        w_busy_d = (w_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt    <= '0;
            r_we_q    <= 1'b0;
            r_addr_q  <= '0;
            r_wdata_q <= '0;
            r_ack     <= 1'b0;
            r_busy    <= 1'b0;
            r_rdata   <= '0;
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
        end else begin
            r_ack  <= w_ack_d;
            r_busy <= w_busy_d;
            if (w_accept) begin
                r_wcnt    <= WCW'(WAIT_CYCLES);
                r_we_q    <= we;
                r_addr_q  <= addr;
                r_wdata_q <= wdata;
            end else if (r_state == WAIT && r_wcnt != '0) begin
                r_wcnt <= r_wcnt - 1'b1;
            end
            // counters move with ack so they are visible in the RESP cycle
            if (w_access) begin
                r_rdata <= r_we_q ? r_wdata_q : w_mem_rdata;
                if (r_we_q) begin
                    if (r_wr_cnt != '1) r_wr_cnt <= r_wr_cnt + 1'b1;
                end else begin
                    if (r_rd_cnt != '1) r_rd_cnt <= r_rd_cnt + 1'b1;
                end
            end
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (r_addr_q),
        .i_wdata (r_wdata_q),
        .o_rdata (w_mem_rdata)
    );

    assign ack    = r_ack;
    assign busy   = r_busy;
    assign rdata  = r_rdata;
    assign rd_cnt = r_rd_cnt;
    assign wr_cnt = r_wr_cnt;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (default, zero wait states, 4-bit counters).
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [2:0]  ack;
    logic [2:0]  busy;
    logic [15:0] rdata0, rdata1, rdata2;
    logic [15:0] rdc0, wrc0, rdc1, wrc1;
    logic [3:0]  rdc2, wrc2;

    int n_total = 0;
    int n_bad   = 0;

    dmem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(2), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req[0]), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack[0]), .rdata(rdata0), .busy(busy[0]), .rd_cnt(rdc0), .wr_cnt(wrc0));

    dmem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(0), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req[1]), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack[1]), .rdata(rdata1), .busy(busy[1]), .rd_cnt(rdc1), .wr_cnt(wrc1));

    dmem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(2), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req(req[2]), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack[2]), .rdata(rdata2), .busy(busy[2]), .rd_cnt(rdc2), .wr_cnt(wrc2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Starts in a cycle just after an edge; returns just after the ack edge with lat = cycles to ack.
    task automatic access(input int sel, input logic w, input logic [7:0] a, input logic [15:0] d,
                          output int lat, output logic [15:0] rd);
        we = w; addr = a; wdata = d; req[sel] = 1'b1; lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ack[sel] && lat < 30);
        req[sel] = 1'b0;
        rd = (sel == 0) ? rdata0 : (sel == 1) ? rdata1 : rdata2;
        if (!ack[sel]) chk("ack_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int          lat;
        int          gap;
        logic [15:0] rd;

        rst_n = 1'b0; req = '0; we = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack",   {29'd0, ack}, 32'd0);
        chk("rst_busy",  {29'd0, busy}, 32'd0);
        chk("rst_rdata", {16'd0, rdata0}, 32'd0);
        chk("rst_cnt0",  {rdc0, wrc0}, 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: store then load, two wait states
        access(0, 1'b1, 8'h05, 16'hBEEF, lat, rd);
        chk("st_lat", lat, 4);
        chk("st_echo", rd, 16'hBEEF);
        chk("st_wrcnt", wrc0, 1);
        chk("st_rdcnt", rdc0, 0);
        @(posedge clk); #1;
        chk("ack_one_cycle", ack[0], 0);
        access(0, 1'b0, 8'h05, 16'h0000, lat, rd);
        chk("ld_lat", lat, 4);
        chk("ld_data", rd, 16'hBEEF);
        chk("ld_rdcnt", rdc0, 1);
        @(posedge clk); #1;
        chk("rdata_hold", rdata0, 16'hBEEF);

        // 2: zero wait states, busy profile
        we = 1'b1; addr = 8'h07; wdata = 16'h5A5A; req[1] = 1'b1;
        @(posedge clk); #1;
        chk("w0_c1_busy", busy[1], 1);
        chk("w0_c1_ack", ack[1], 0);
        @(posedge clk); #1;
        chk("w0_c2_busy", busy[1], 1);
        chk("w0_c2_ack", ack[1], 1);
        chk("w0_c2_data", rdata1, 16'h5A5A);
        req[1] = 1'b0;
        @(posedge clk); #1;
        chk("w0_c3_busy", busy[1], 0);
        chk("w0_c3_ack", ack[1], 0);
        access(1, 1'b0, 8'h07, 16'h0000, lat, rd);
        chk("w0_ld_lat", lat, 2);
        chk("w0_ld_data", rd, 16'h5A5A);

        // 3: back-to-back with req held across ack
        we = 1'b1; addr = 8'h30; wdata = 16'h1111; req[0] = 1'b1; lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ack[0] && lat < 30);
        chk("b2b_first_lat", lat, 4);
        we = 1'b0; addr = 8'h05;
        @(posedge clk); #1;
        chk("b2b_no_consec", ack[0], 0);
        gap = 1;
        while (!ack[0] && gap < 30) begin
            @(posedge clk); #1;
            gap++;
        end
        req[0] = 1'b0;
        chk("b2b_gap", gap, 5);
        chk("b2b_data", rdata0, 16'hBEEF);
        chk("b2b_cnts", {rdc0, wrc0}, {16'd2, 16'd2});
        @(posedge clk); #1;

        // 4: request committed once accepted
        we = 1'b1; addr = 8'h10; wdata = 16'h1234; req[0] = 1'b1; lat = 0;
        @(posedge clk); #1;
        lat = 1;
        req[0] = 1'b0; wdata = 16'hFFFF; addr = 8'h11; we = 1'b0;
        while (!ack[0] && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("commit_lat", lat, 4);
        chk("commit_echo", rdata0, 16'h1234);
        @(posedge clk); #1;
        access(0, 1'b0, 8'h10, 16'h0000, lat, rd);
        chk("commit_ld", rd, 16'h1234);
        chk("commit_cnts", {rdc0, wrc0}, {16'd3, 16'd3});
        @(posedge clk); #1;

        // 5: reset during WAIT aborts the store
        access(0, 1'b1, 8'h20, 16'hAAAA, lat, rd);
        chk("pre_st_lat", lat, 4);
        @(posedge clk); #1;
        we = 1'b1; addr = 8'h20; wdata = 16'h5555; req[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_in_wait", busy[0], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ack", ack[0], 0);
        chk("abort_busy", busy[0], 0);
        chk("abort_rdata", rdata0, 0);
        chk("abort_cnts", {rdc0, wrc0}, 32'd0);
        req[0] = 1'b0;
        #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("abort_no_ack", ack[0], 0);
        end
        access(0, 1'b0, 8'h20, 16'h0000, lat, rd);
        chk("abort_ld", rd, 16'hAAAA);
        chk("abort_ld_cnts", {rdc0, wrc0}, {16'd1, 16'd0});
        @(posedge clk); #1;

        // 6: 4-bit counter saturation
        for (int i = 0; i < 15; i++) begin
            access(2, 1'b0, 8'h05, 16'h0000, lat, rd);
            @(posedge clk); #1;
        end
        chk("cnt_at_15", rdc2, 4'hF);
        for (int i = 0; i < 2; i++) begin
            access(2, 1'b0, 8'h05, 16'h0000, lat, rd);
            @(posedge clk); #1;
        end
        chk("cnt_sat", rdc2, 4'hF);
        chk("cnt_wr_untouched", wrc2, 4'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
